multi_cycle_ctrl: RTL and testbench



---
 rtl/multi_cycle_ctrl_if.sv | 29 ++
 rtl/multi_cycle_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Control-unit bundle: opcode/flag inputs from the datapath and every
// write-enable, mux select and extender select the control unit drives back.
interface multi_cycle_ctrl_if;
  logic [5:0] Opcode;
  logic       Zero;
  logic       PCWre;
  logic       IRWre;
  logic       ExtSel;
  logic       ALUSrcB;
  logic [2:0] ALUOp;
  logic       RegWre;
  logic       RegDst;
  logic       DBDataSrc;
  logic       DataMemWr;
  logic [1:0] PCSrc;
  logic       Halted;

  modport master (
    output Opcode, Zero,
    input  PCWre, IRWre, ExtSel, ALUSrcB, ALUOp, RegWre, RegDst,
           DBDataSrc, DataMemWr, PCSrc, Halted
  );

  modport slave (
    input  Opcode, Zero,
    output PCWre, IRWre, ExtSel, ALUSrcB, ALUOp, RegWre, RegDst,
           DBDataSrc, DataMemWr, PCSrc, Halted
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences IF/ID/EXE/MEM/WB
// from a latched opcode and drives every datapath enable, mux select and ExtSel.
module multi_cycle_ctrl #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input logic               CLK,
  input logic               RST,
  multi_cycle_ctrl_if.slave bus
);
  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPW-1:0] OP_AND  = 6'b010000;
  localparam logic [OPW-1:0] OP_OR   = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
  localparam logic [OPW-1:0] OP_SLT  = 6'b011000;
  localparam logic [OPW-1:0] OP_SW   = 6'b110000;
  localparam logic [OPW-1:0] OP_LW   = 6'b110001;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OPW-1:0] OP_J    = 6'b111000;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  state_e         state_q, state_d;
  logic           halt_q, halt_d;
  logic [OPW-1:0] op_q, op_d;

  logic       pcwre_s, irwre_s, extsel_s, alusrcb_s;
  logic [2:0] aluop_s;
  logic       regwre_s, regdst_s, dbdatasrc_s, datamemwr_s, halted_s;
  logic [1:0] pcsrc_s;

  function automatic logic is_halt(input logic [OPW-1:0] op);
    return op == HALT_OP;
  endfunction

  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return !is_halt(op) && (op == OP_ADD || op == OP_SUB || op == OP_AND ||
                            op == OP_OR  || op == OP_SLT);
  endfunction

  function automatic logic is_imm_al(input logic [OPW-1:0] op);
    return !is_halt(op) && (op == OP_ADDI || op == OP_ORI);
  endfunction

  function automatic logic is_al(input logic [OPW-1:0] op);
    return is_rtype(op) || is_imm_al(op);
  endfunction

  function automatic logic is_ls(input logic [OPW-1:0] op);
    return !is_halt(op) && (op == OP_LW || op == OP_SW);
  endfunction

  function automatic logic is_beq(input logic [OPW-1:0] op);
    return !is_halt(op) && (op == OP_BEQ);
  endfunction

  function automatic logic is_jmp(input logic [OPW-1:0] op);
    return !is_halt(op) && (op == OP_J);
  endfunction

  function automatic logic is_nop(input logic [OPW-1:0] op);
    return !(is_halt(op) || is_al(op) || is_ls(op) || is_beq(op) || is_jmp(op));
  endfunction

  // Sign-extension is needed for arithmetic immediates, address offsets and branch offsets.
  function automatic logic sign_ext(input logic [OPW-1:0] op);
    return !is_halt(op) && (op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_BEQ);
  endfunction

  function automatic logic [2:0] alu_ctl(input logic [OPW-1:0] op);
    logic [2:0] ctl;
    case (op)
      OP_ADD, OP_ADDI: ctl = 3'b000;
      OP_SUB:          ctl = 3'b001;
      OP_AND:          ctl = 3'b010;
      OP_OR, OP_ORI:   ctl = 3'b011;
      OP_SLT:          ctl = 3'b100;
      default:         ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  // State, halt flag and in-flight opcode registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IF;
      halt_q  <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      op_q    <= op_d;
    end
  end

  // Next-state decode; ID looks at the live opcode, later states only at op_q.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    op_d    = op_q;
    if (halt_q) begin
      halt_d = 1'b1;
    end else begin
      case (state_q)
        S_IF: state_d = S_ID;
        S_ID: begin
          op_d = bus.Opcode;
          if (is_halt(bus.Opcode)) begin
            halt_d  = 1'b1;
            state_d = S_IF;
          end else if (is_al(bus.Opcode)) begin
            state_d = S_EXE_AL;
          end else if (is_ls(bus.Opcode)) begin
            state_d = S_EXE_LS;
          end else if (is_beq(bus.Opcode)) begin
            state_d = S_EXE_BR;
          end else begin
            state_d = S_IF;
          end
        end
        S_EXE_AL: state_d = S_WB_AL;
        S_WB_AL:  state_d = S_IF;
        S_EXE_LS: state_d = S_MEM;
        S_MEM: begin
          if (op_q == OP_LW) begin
            state_d = S_WB_LD;
          end else begin
            state_d = S_IF;
          end
        end
        S_WB_LD:  state_d = S_IF;
        S_EXE_BR: state_d = S_IF;
        default:  state_d = S_IF;
      endcase
    end
  end

  // Output decode; RST low forces every output to zero without waiting for a clock.
  always_comb begin
    pcwre_s     = 1'b0;
    irwre_s     = 1'b0;
    extsel_s    = 1'b0;
    alusrcb_s   = 1'b0;
    aluop_s     = 3'b000;
    regwre_s    = 1'b0;
    regdst_s    = 1'b0;
    dbdatasrc_s = 1'b0;
    datamemwr_s = 1'b0;
    pcsrc_s     = 2'b00;
    halted_s    = 1'b0;
    if (!RST) begin
      halted_s = 1'b0;
    end else if (halt_q) begin
      halted_s = 1'b1;
    end else begin
      case (state_q)
        S_IF: irwre_s = 1'b1;
        S_ID: begin
          extsel_s = sign_ext(bus.Opcode);
          if (is_jmp(bus.Opcode)) begin
            pcwre_s = 1'b1;
            pcsrc_s = 2'b10;
          end else if (is_nop(bus.Opcode)) begin
            pcwre_s = 1'b1;
            pcsrc_s = 2'b00;
          end else begin
            pcwre_s = 1'b0;
          end
        end
        S_EXE_AL: begin
          extsel_s  = sign_ext(op_q);
          alusrcb_s = is_imm_al(op_q);
          aluop_s   = alu_ctl(op_q);
        end
        S_WB_AL: begin
          extsel_s  = sign_ext(op_q);
          alusrcb_s = is_imm_al(op_q);
          aluop_s   = alu_ctl(op_q);
          regwre_s  = 1'b1;
          regdst_s  = is_rtype(op_q);
          pcwre_s   = 1'b1;
          pcsrc_s   = 2'b00;
        end
        S_EXE_LS: begin
          extsel_s  = sign_ext(op_q);
          alusrcb_s = 1'b1;
          aluop_s   = 3'b000;
        end
        S_MEM: begin
          // Address path stays selected so the memory sees a stable address.
          extsel_s  = sign_ext(op_q);
          alusrcb_s = 1'b1;
          aluop_s   = 3'b000;
          if (op_q == OP_SW) begin
            datamemwr_s = 1'b1;
            pcwre_s     = 1'b1;
            pcsrc_s     = 2'b00;
          end else begin
            datamemwr_s = 1'b0;
          end
        end
        S_WB_LD: begin
          extsel_s    = sign_ext(op_q);
          regwre_s    = 1'b1;
          regdst_s    = 1'b0;
          dbdatasrc_s = 1'b1;
          pcwre_s     = 1'b1;
          pcsrc_s     = 2'b00;
        end
        S_EXE_BR: begin
          extsel_s = sign_ext(op_q);
          aluop_s  = 3'b001;
          pcwre_s  = 1'b1;
          if (bus.Zero) begin
            pcsrc_s = 2'b01;
          end else begin
            pcsrc_s = 2'b00;
          end
        end
        default: halted_s = 1'b0;
      endcase
    end
  end

  assign bus.PCWre     = pcwre_s;
  assign bus.IRWre     = irwre_s;
  assign bus.ExtSel    = extsel_s;
  assign bus.ALUSrcB   = alusrcb_s;
  assign bus.ALUOp     = aluop_s;
  assign bus.RegWre    = regwre_s;
  assign bus.RegDst    = regdst_s;
  assign bus.DBDataSrc = dbdatasrc_s;
  assign bus.DataMemWr = datamemwr_s;
  assign bus.PCSrc     = pcsrc_s;
  assign bus.Halted    = halted_s;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class state by
// state and compares the full control word against hand-derived values.
module tb_multi_cycle_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl #(.HALT_OP(6'b111111)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Control word order: PCWre IRWre ExtSel ALUSrcB ALUOp RegWre RegDst DBDataSrc DataMemWr PCSrc Halted
  function automatic logic [13:0] ev(input logic pcw, input logic irw, input logic ext,
                                     input logic srcb, input logic [2:0] alu,
                                     input logic regw, input logic regdst,
                                     input logic dbsrc, input logic memwr,
                                     input logic [1:0] pcsrc, input logic halted);
    return {pcw, irw, ext, srcb, alu, regw, regdst, dbsrc, memwr, pcsrc, halted};
  endfunction

  task automatic chk(input string tag, input logic [13:0] expv);
    logic [13:0] obs;
    obs = {bus.PCWre, bus.IRWre, bus.ExtSel, bus.ALUSrcB, bus.ALUOp, bus.RegWre,
           bus.RegDst, bus.DBDataSrc, bus.DataMemWr, bus.PCSrc, bus.Halted};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  logic [13:0] E_ZERO, E_IF, E_HALT;

  initial begin
    E_ZERO = ev(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    E_IF   = ev(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    E_HALT = ev(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    RST        = 1'b0;
    bus.Opcode = 6'b000000;
    bus.Zero   = 1'b0;
    #2;
    chk("reset_hold", E_ZERO);
    #10;
    RST = 1'b1;
    #1;
    chk("release_if", E_IF);

    // add, aborted by reset in EXE_AL
    tick();
    chk("add_id", E_ZERO);
    tick();
    chk("add_exe", E_ZERO);
    #1;
    RST = 1'b0;
    #1;
    chk("rst_mid_exe", E_ZERO);
    #8;
    chk("rst_across_edge", E_ZERO);
    bus.Opcode = 6'b000010;
    RST        = 1'b1;
    #1;
    chk("rst_rel_if", E_IF);

    // addi
    tick();
    chk("addi_id", ev(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("addi_exe", ev(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("addi_wb", ev(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));

    // ori, with the opcode input disturbed mid-instruction
    tick();
    bus.Opcode = 6'b010010;
    #1;
    chk("ori_if", E_IF);
    tick();
    chk("ori_id", E_ZERO);
    tick();
    bus.Opcode = 6'b110001;
    #1;
    chk("ori_exe", ev(1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("ori_wb", ev(1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));

    // lw (opcode already 110001)
    tick();
    chk("lw_if", E_IF);
    tick();
    chk("lw_id", ev(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("lw_exe", ev(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("lw_mem", ev(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("lw_wb", ev(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0));

    // sw
    tick();
    bus.Opcode = 6'b110000;
    #1;
    chk("sw_if", E_IF);
    tick();
    chk("sw_id", ev(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("sw_exe", ev(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("sw_mem", ev(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0));

    // sub (R-type writes rd)
    tick();
    bus.Opcode = 6'b000001;
    #1;
    chk("sub_if", E_IF);
    tick();
    chk("sub_id", E_ZERO);
    tick();
    chk("sub_exe", ev(1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("sub_wb", ev(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));

    // beq taken
    tick();
    bus.Opcode = 6'b110100;
    bus.Zero   = 1'b1;
    #1;
    chk("beq1_if", E_IF);
    tick();
    chk("beq1_id", ev(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    tick();
    chk("beq1_exe", ev(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0));

    // beq not taken
    tick();
    bus.Zero = 1'b0;
    #1;
    chk("beq0_if", E_IF);
    tick();
    tick();
    chk("beq0_exe", ev(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));

    // j
    tick();
    bus.Opcode = 6'b111000;
    #1;
    chk("j_if", E_IF);
    tick();
    chk("j_id", ev(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0));

    // unknown opcode behaves as a NOP
    tick();
    bus.Opcode = 6'b101010;
    #1;
    chk("nop_if", E_IF);
    tick();
    chk("nop_id", ev(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));

    // halt, then parked for 20 cycles regardless of the opcode input
    tick();
    bus.Opcode = 6'b111111;
    #1;
    chk("halt_if", E_IF);
    tick();
    chk("halt_id", E_ZERO);
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.Opcode = (i % 2 == 0) ? 6'b000000 : 6'b111000;
      #1;
      chk($sformatf("halt_park_%0d", i), E_HALT);
    end

    RST = 1'b0;
    #1;
    chk("halt_rst", E_ZERO);
    RST = 1'b1;
    #1;
    chk("halt_rel_if", E_IF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
